// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard and redirect sequencer for the pc -> if_id -> id_ex -> ex pipeline.
// It turns ex-stage jumps, load-use hazards, multi-cycle-unit busy and debug halt
// into a pc load, per-stage hold (stall) and bubble-insert (flush) controls.
//
//  state | meaning
//  ------+-----------------------------------------------------------------
//  RUN   | normal flow; events are sampled by priority jump > busy > lu > halt
//  FLUSH | bubbles still draining after a redirect; cnt counts down to RUN
//  LU    | extra load-use stall cycles; cnt counts down to RUN
//  HALT  | debug halt: front end held, ex fed bubbles, halted_o high
module pipe_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int FLUSH_CYC = 2,
    parameter int LU_STALL  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_en_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              load_use_i,
    input  logic              mdu_busy_i,
    input  logic              halt_req_i,
    output logic              pc_load_o,
    output logic [ADDR_W-1:0] pc_load_addr_o,
    output logic              stall_pc_o,
    output logic              stall_if_id_o,
    output logic              stall_id_ex_o,
    output logic              flush_if_id_o,
    output logic              flush_id_ex_o,
    output logic              halted_o,
    output logic [1:0]        state_o
);

    localparam int MAX_CYC = (FLUSH_CYC > LU_STALL) ? FLUSH_CYC : LU_STALL;
    localparam int CW      = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);

    // Preload values for the down-counter; the current cycle is already one of the
    // counted cycles, and the terminal cycle is the one where cnt reads zero.
    localparam logic [CW-1:0] FLUSH_INIT = CW'((FLUSH_CYC >= 2) ? FLUSH_CYC - 2 : 0);
    localparam logic [CW-1:0] LU_INIT    = CW'((LU_STALL  >= 2) ? LU_STALL  - 2 : 0);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        LU    = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t        state, nxt_state;
    logic [CW-1:0] cnt, nxt_cnt;

    // Output decode and next-state selection; reset overrides everything.
    always_comb begin
        pc_load_o      = 1'b0;
        pc_load_addr_o = jump_addr_i;
        stall_pc_o     = 1'b0;
        stall_if_id_o  = 1'b0;
        stall_id_ex_o  = 1'b0;
        flush_if_id_o  = 1'b0;
        flush_id_ex_o  = 1'b0;
        halted_o       = 1'b0;
        nxt_state      = state;
        nxt_cnt        = cnt;

        if (rst) begin
            flush_if_id_o  = 1'b1;
            flush_id_ex_o  = 1'b1;
            pc_load_addr_o = '0;
            nxt_state      = RUN;
            nxt_cnt        = '0;
        end else if (state != HALT && jump_en_i) begin
            // A redirect wins everywhere outside HALT and restarts any sequence.
            pc_load_o     = 1'b1;
            flush_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
            if (FLUSH_CYC <= 1) begin
                nxt_state = RUN;
                nxt_cnt   = '0;
            end else begin
                nxt_state = FLUSH;
                nxt_cnt   = FLUSH_INIT;
            end
        end else begin
            case (state)
                RUN: begin
                    if (mdu_busy_i) begin
                        stall_pc_o    = 1'b1;
                        stall_if_id_o = 1'b1;
                        stall_id_ex_o = 1'b1;
                    end else if (load_use_i) begin
                        stall_pc_o    = 1'b1;
                        stall_if_id_o = 1'b1;
                        flush_id_ex_o = 1'b1;
                        if (LU_STALL > 1) begin
                            nxt_state = LU;
                            nxt_cnt   = LU_INIT;
                        end
                    end else if (halt_req_i) begin
                        nxt_state = HALT;
                    end
                end
                FLUSH: begin
                    flush_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                    if (cnt == '0) nxt_state = RUN;
                    else           nxt_cnt   = cnt - 1'b1;
                end
                LU: begin
                    stall_pc_o    = 1'b1;
                    stall_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                    if (cnt == '0) nxt_state = RUN;
                    else           nxt_cnt   = cnt - 1'b1;
                end
                HALT: begin
                    stall_pc_o    = 1'b1;
                    stall_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                    halted_o      = 1'b1;
                    if (!halt_req_i) nxt_state = RUN;
                end
                default: begin
                    nxt_state = RUN;
                    nxt_cnt   = '0;
                end
            endcase
        end
    end

    // State and down-counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= nxt_state;
            cnt   <= nxt_cnt;
        end
    end

    assign state_o = state;

endmodule
